// File: rtl/banner_rotator_if.sv
// banner_rotator_if: control inputs and digit outputs of the banner rotator
interface banner_rotator_if #(
  parameter int N_DIGITS = 10
) ();
  localparam int PW = $clog2(N_DIGITS);
  logic                  en_i;
  logic                  dir_i;
  logic                  load_i;
  logic [4*N_DIGITS-1:0] msg_i;
  logic [3:0]            in0_o;
  logic [3:0]            in1_o;
  logic [3:0]            in2_o;
  logic [3:0]            in3_o;
  logic [PW-1:0]         pos_o;
  logic                  step_o;
  modport master (
    output en_i, dir_i, load_i, msg_i,
    input  in0_o, in1_o, in2_o, in3_o, pos_o, step_o
  );
  modport slave (
    input  en_i, dir_i, load_i, msg_i,
    output in0_o, in1_o, in2_o, in3_o, pos_o, step_o
  );
endinterface

// File: rtl/banner_rotator.sv
// banner_rotator: rotates a stored digit message into four mux digit slots
module banner_rotator #(
  parameter int N_DIGITS   = 10,
  parameter int TICK_COUNT = 50_000_000
) (
  input logic             clk_i,
  input logic             rst_ni,
  banner_rotator_if.slave bus
);
  localparam int PW = $clog2(N_DIGITS);
  localparam int TW = $clog2(TICK_COUNT);
  localparam logic [PW-1:0] P_LAST = PW'(N_DIGITS - 1);
  localparam logic [PW-1:0] P_ONE  = PW'(1);
  localparam logic [TW-1:0] T_LAST = TW'(TICK_COUNT - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  logic [4*N_DIGITS-1:0] msg_q, msg_d;
  logic [PW-1:0]         pos_q, pos_d;
  logic [TW-1:0]         tick_q, tick_d;
  logic                  step_q, step_d;
  logic                  term;
  // wrap via compare-and-subtract; pos+k never exceeds 2*N_DIGITS-1
  function automatic logic [3:0] digit_at(input logic [4*N_DIGITS-1:0] m,
                                          input logic [PW-1:0] p, input int k);
    logic [PW:0] s;
    s = {1'b0, p} + (PW+1)'(k);
    s = s >= (PW+1)'(N_DIGITS) ? s - (PW+1)'(N_DIGITS) : s;
    return m[4*s +: 4];
  endfunction
  always_comb begin
    term   = bus.en_i && tick_q == T_LAST;
    msg_d  = bus.load_i ? bus.msg_i : msg_q;
    tick_d = bus.load_i ? '0 : !bus.en_i ? tick_q : term ? '0 : tick_q + T_ONE;
    step_d = !bus.load_i && term;
    pos_d  = bus.load_i ? '0 :
             !term      ? pos_q :
             bus.dir_i  ? (pos_q == '0 ? P_LAST : pos_q - P_ONE) :
                          (pos_q == P_LAST ? '0 : pos_q + P_ONE);
  end
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      msg_q  <= '0;
      pos_q  <= '0;
      tick_q <= '0;
      step_q <= 1'b0;
    end else begin
      msg_q  <= msg_d;
      pos_q  <= pos_d;
      tick_q <= tick_d;
      step_q <= step_d;
    end
  assign bus.in3_o  = digit_at(msg_q, pos_q, 0);
  assign bus.in2_o  = digit_at(msg_q, pos_q, 1);
  assign bus.in1_o  = digit_at(msg_q, pos_q, 2);
  assign bus.in0_o  = digit_at(msg_q, pos_q, 3);
  assign bus.pos_o  = pos_q;
  assign bus.step_o = step_q;
endmodule

// File: tb/tb_banner_rotator.sv
// tb_banner_rotator: scoreboard bench for banner_rotator with a reference model
module tb_banner_rotator;
  localparam int ND = 10;
  localparam int TC = 4;
  typedef struct packed {
    logic [3:0]  pos;
    logic        step;
    logic [15:0] dig;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t act;
  logic [4*ND-1:0] m_msg;
  int   m_pos, m_tick;
  logic m_step;
  banner_rotator_if #(.N_DIGITS(ND)) bus ();
  banner_rotator #(.N_DIGITS(ND), .TICK_COUNT(TC)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  assign act = {bus.pos_o, bus.step_o, bus.in3_o, bus.in2_o, bus.in1_o, bus.in0_o};
  function automatic exp_t predict();
    exp_t e;
    if (!rst_n) begin
      m_msg = '0; m_pos = 0; m_tick = 0; m_step = 1'b0;
    end else if (bus.load_i) begin
      m_msg = bus.msg_i; m_pos = 0; m_tick = 0; m_step = 1'b0;
    end else if (bus.en_i) begin
      m_step = (m_tick == TC - 1);
      if (m_step) begin
        m_tick = 0;
        m_pos  = bus.dir_i ? (m_pos + ND - 1) % ND : (m_pos + 1) % ND;
      end else m_tick++;
    end else m_step = 1'b0;
    e.pos  = 4'(m_pos);
    e.step = m_step;
    for (int k = 0; k < 4; k++) e.dig[15-4*k -: 4] = m_msg[4*((m_pos + k) % ND) +: 4];
    return e;
  endfunction
  task automatic cyc();
    sb.push_back(predict());
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc(); e = sb.pop_front(); n_checks++;
      if (act !== e) begin n_fail++; $display("FAIL reset[%0d]: got %h want %h", i, act, e); end
      n_checks++;
      if (act !== 21'h0) begin n_fail++; $display("FAIL reset_zero[%0d]: got %h want 0", i, act); end
    end
    rst_n = 1'b1;
    bus.load_i = 1'b1;
    bus.msg_i = 40'h9876543210;
    cyc(); e = sb.pop_front(); n_checks++;
    bus.load_i = 1'b0;
    if (act !== e) begin n_fail++; $display("FAIL load: got %h want %h", act, e); end
    n_checks++;
    if (act !== {4'd0, 1'b0, 16'h0123}) begin n_fail++; $display("FAIL load_const: got %h want %h", act, {4'd0, 1'b0, 16'h0123}); end
  endtask
  task automatic test_left();
    exp_t e, w;
    bus.en_i = 1'b1; bus.dir_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc(); e = sb.pop_front(); n_checks++;
      if (act !== e) begin n_fail++; $display("FAIL left[%0d]: got %h want %h", i, act, e); end
      if (i == 3 || i == 35 || i == 39) begin
        w = i == 3 ? {4'd1, 1'b1, 16'h1234} : i == 35 ? {4'd9, 1'b1, 16'h9012} : {4'd0, 1'b1, 16'h0123};
        n_checks++;
        if (act !== w) begin n_fail++; $display("FAIL left_const[%0d]: got %h want %h", i, act, w); end
      end
    end
  endtask
  task automatic test_right();
    exp_t e, w;
    bus.dir_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(); e = sb.pop_front(); n_checks++;
      if (act !== e) begin n_fail++; $display("FAIL right[%0d]: got %h want %h", i, act, e); end
      if (i == 3 || i == 7) begin
        w = i == 3 ? {4'd9, 1'b1, 16'h9012} : {4'd8, 1'b1, 16'h8901};
        n_checks++;
        if (act !== w) begin n_fail++; $display("FAIL right_const[%0d]: got %h want %h", i, act, w); end
      end
    end
  endtask
  task automatic test_pause();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      cyc(); e = sb.pop_front(); n_checks++;
      if (act !== e) begin n_fail++; $display("FAIL pre_pause[%0d]: got %h want %h", i, act, e); end
    end
    bus.en_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.msg_i = {$urandom, 8'($urandom)};
      cyc(); e = sb.pop_front(); n_checks++;
      if (act !== e) begin n_fail++; $display("FAIL pause[%0d]: got %h want %h", i, act, e); end
      n_checks++;
      if (act.step !== 1'b0 || act.pos !== 4'd8) begin
        n_fail++; $display("FAIL pause_hold[%0d]: got pos %0d step %b want pos 8 step 0", i, act.pos, act.step);
      end
    end
    bus.en_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc(); e = sb.pop_front(); n_checks++;
      if (act !== e) begin n_fail++; $display("FAIL resume[%0d]: got %h want %h", i, act, e); end
    end
    n_checks++;
    if (act !== {4'd7, 1'b1, 16'h7890}) begin n_fail++; $display("FAIL resume_step: got %h want %h", act, {4'd7, 1'b1, 16'h7890}); end
  endtask
  task automatic test_collision();
    exp_t e, w;
    for (int i = 0; i < 3; i++) begin
      cyc(); e = sb.pop_front(); n_checks++;
      if (act !== e) begin n_fail++; $display("FAIL pre_coll[%0d]: got %h want %h", i, act, e); end
    end
    bus.load_i = 1'b1;
    bus.msg_i = 40'hAAAAAAAAA5;
    cyc(); e = sb.pop_front(); n_checks++;
    bus.load_i = 1'b0;
    if (act !== e) begin n_fail++; $display("FAIL coll: got %h want %h", act, e); end
    n_checks++;
    if (act !== {4'd0, 1'b0, 16'h5AAA}) begin n_fail++; $display("FAIL coll_const: got %h want %h", act, {4'd0, 1'b0, 16'h5AAA}); end
    bus.dir_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(); e = sb.pop_front(); n_checks++;
      if (act !== e) begin n_fail++; $display("FAIL post_coll[%0d]: got %h want %h", i, act, e); end
      w = i == 3 ? {4'd1, 1'b1, 16'hAAAA} : {4'd0, 1'b0, 16'h5AAA};
      n_checks++;
      if (act !== w) begin n_fail++; $display("FAIL post_coll_const[%0d]: got %h want %h", i, act, w); end
    end
  endtask
  task automatic test_reset_mid();
    exp_t e, w;
    for (int i = 0; i < 23; i++) begin
      cyc(); e = sb.pop_front(); n_checks++;
      if (act !== e) begin n_fail++; $display("FAIL pre_rst[%0d]: got %h want %h", i, act, e); end
    end
    n_checks++;
    if (act.pos !== 4'd6) begin n_fail++; $display("FAIL pre_rst_pos: got %0d want 6", act.pos); end
    rst_n = 1'b0;
    cyc(); e = sb.pop_front(); n_checks++;
    rst_n = 1'b1;
    if (act !== e) begin n_fail++; $display("FAIL mid_rst: got %h want %h", act, e); end
    n_checks++;
    if (act !== 21'h0) begin n_fail++; $display("FAIL mid_rst_zero: got %h want 0", act); end
    for (int i = 0; i < 4; i++) begin
      cyc(); e = sb.pop_front(); n_checks++;
      if (act !== e) begin n_fail++; $display("FAIL post_rst[%0d]: got %h want %h", i, act, e); end
      w = i == 3 ? {4'd1, 1'b1, 16'h0000} : 21'h0;
      n_checks++;
      if (act !== w) begin n_fail++; $display("FAIL post_rst_const[%0d]: got %h want %h", i, act, w); end
    end
  endtask
  initial begin
    rst_n = 1'b0;
    bus.en_i = 1'b0;
    bus.dir_i = 1'b0;
    bus.load_i = 1'b0;
    bus.msg_i = '0;
    #1;
    test_reset();
    test_left();
    test_right();
    test_pause();
    test_collision();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/banner_rotator.md
Name: banner_rotator

Overview:
- Upstream stage of the seven-segment time multiplexer in the rotating LED banner.
- Holds an N_DIGITS-digit 4-bit message and a rotation offset.
- Drives four 4-bit digit codes to the multiplexer's digit inputs: in3 is the leftmost digit and in0 the rightmost.
- Advances the offset once every TICK_COUNT enabled clocks, in either direction, wrapping around the message.

Parameters:
- N_DIGITS, 10, number of 4-bit digits in the message; legal range 4..16.
- TICK_COUNT, 50_000_000, enabled clock cycles per rotation step; must be >= 2.

Ports:
- clk_i  input  1  system clock; all logic is on the rising edge.
- rst_ni  input  1  synchronous reset, active-low.
- en_i  input  1  rotation enable; 0 pauses rotation.
- dir_i  input  1  0 = scroll left (offset increments), 1 = scroll right (offset decrements).
- load_i  input  1  single-cycle strobe that captures msg_i.
- msg_i  input  4*N_DIGITS  message; digit k = msg_i[4k+3:4k].
- in0_o, in1_o, in2_o, in3_o  output  4 each  digit codes sent to the multiplexer.
- pos_o  output  $clog2(N_DIGITS)  current rotation offset.
- step_o  output  1  one-cycle pulse, registered, asserted on the cycle the offset changes.

Behaviour:
- State registers:
  - msg_q: 4*N_DIGITS bits.
  - pos_q: 0..N_DIGITS-1.
  - tick_q: 0..TICK_COUNT-1, width $clog2(TICK_COUNT).
  - step_q.
- Reset (rst_ni=0 at a clock edge):
  - msg_q=0, pos_q=0, tick_q=0, step_q=0.
  - All in*_o=0, pos_o=0, step_o=0.
  - Reset overrides every other input, including load_i.
- Output decode is combinational from registers, with no added latency:
  - in3_o = digit[pos_q]
  - in2_o = digit[(pos_q+1) mod N_DIGITS]
  - in1_o = digit[(pos_q+2) mod N_DIGITS]
  - in0_o = digit[(pos_q+3) mod N_DIGITS]
  - Modulo uses compare-and-subtract, not a divider.
  - pos_o = pos_q.
- Priority each cycle, highest first: reset, load, tick.
- Load (load_i=1):
  - msg_q <= msg_i, pos_q <= 0, tick_q <= 0, step_q <= 0.
  - Load works regardless of en_i.
  - A terminal tick in the same cycle is discarded: no step, no pulse.
- Tick (en_i=1, no load):
  - If tick_q == TICK_COUNT-1: tick_q <= 0, step_q <= 1, pos_q advances.
  - Otherwise: tick_q <= tick_q+1, step_q <= 0.
- Pos advance:
  - dir_i=0: pos_q = N_DIGITS-1 wraps to 0, else +1.
  - dir_i=1: pos_q = 0 wraps to N_DIGITS-1, else -1.
  - dir_i is sampled only on the terminal cycle.
  - Changing dir_i mid-count does not reset tick_q.
- Pause (en_i=0, no load): tick_q and pos_q hold, step_q <= 0. Re-enabling resumes from the held tick_q.
- step_o goes high on the same edge pos_q updates and stays high exactly one cycle. Step pulses are spaced exactly TICK_COUNT cycles apart while enabled.
- msg_i is ignored except on load cycles. The message is stable between loads.
- Reset mid-count returns to pos 0 with a cleared message. The first step after reset comes TICK_COUNT enabled cycles later.

Test Plan:
Bench uses TICK_COUNT=4, N_DIGITS=10.
- Reset then load: rst_ni low 2 cycles, then load_i with msg_i=40'h9876543210 -> in3..in0 = 0,1,2,3; pos_o=0; step_o=0.
- Left scroll: en_i=1, dir_i=0 for 4 cycles after load -> step_o high on the 4th edge only; pos_o=1; in3..in0 = 1,2,3,4. After 36 more cycles (10 steps total), pos_o=0. At pos_o=9, in3..in0 = 9,0,1,2.
- Right scroll wrap: from pos_o=0 set dir_i=1 for 4 cycles -> pos_o=9; in3..in0 = 9,0,1,2. After 4 more cycles, pos_o=8.
- Pause: en_i=0 for 20 cycles with tick_q=2 -> no step_o, pos_o unchanged. Re-enable -> step_o after exactly 2 cycles.
- Load collision: load_i asserted on the terminal tick cycle with msg_i=40'hAAAAAAAAA5 -> pos_o=0, step_o stays 0, in3..in0 = 5,A,A,A. Next step after 4 enabled cycles.
- Reset mid-operation: rst_ni low at pos_o=6, tick_q=3 -> next cycle all outputs 0. After release with en_i=1, the first step_o comes 4 cycles later and pos_o=1.
